// File: rtl/vector_stream_splitter.sv
// Streams one IN_W-bit word out as IN_W/SLICE_W slices, one per out handshake, MSB- or LSB-slice first.
// Optional VSPLIT_PARITY_EN adds out_par, the even parity of the current slice.
module vector_stream_splitter #(
  parameter int IN_W      = 8,
  parameter int SLICE_W   = 2,
  parameter int MSB_FIRST = 1,
  localparam int NSLICE   = IN_W / SLICE_W,
  localparam int IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
`ifdef VSPLIT_PARITY_EN
  ,
  output logic               out_par
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (SLICE_W < 1 || SLICE_W > IN_W || (IN_W % SLICE_W) != 0) begin : g_bad_params
      $error("vector_stream_splitter: IN_W must be a non-zero multiple of SLICE_W");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_reg;
  logic [IN_W-1:0]    word_reg;
  logic [SLICE_W-1:0] in_slice   [NSLICE];
  logic [SLICE_W-1:0] word_slice [NSLICE];
  logic [IDX_W-1:0]   idx_next;
  logic               take;

  // Slices are numbered in emission order, so index 0 is always the first one sent.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      if (MSB_FIRST != 0) begin : g_msb
        assign in_slice[gi]   = in_data[IN_W-1-gi*SLICE_W -: SLICE_W];
        assign word_slice[gi] = word_reg[IN_W-1-gi*SLICE_W -: SLICE_W];
      end else begin : g_lsb
        assign in_slice[gi]   = in_data[gi*SLICE_W +: SLICE_W];
        assign word_slice[gi] = word_reg[gi*SLICE_W +: SLICE_W];
      end
    end
  endgenerate

  // Accepting on the final-slice handshake keeps the output busy every cycle.
  assign in_ready = (state_reg == IDLE) || (out_last && out_ready);
  assign take     = in_valid && in_ready;
  assign idx_next = out_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
`ifdef VSPLIT_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (take) begin
      state_reg <= SEND;
      word_reg  <= in_data;
      out_valid <= 1'b1;
      out_data  <= in_slice[0];
      out_idx   <= '0;
      out_last  <= (LAST_IDX == '0);
`ifdef VSPLIT_PARITY_EN
      out_par   <= ^in_slice[0];
`endif
    end else if (state_reg == SEND && out_ready) begin
      if (!out_last) begin
        out_idx   <= idx_next;
        out_data  <= word_slice[idx_next];
        out_last  <= (idx_next == LAST_IDX);
`ifdef VSPLIT_PARITY_EN
        out_par   <= ^word_slice[idx_next];
`endif
      end else begin
        state_reg <= IDLE;
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_stream_splitter.sv
// Directed bench: one MSB-first and one LSB-first splitter share the same stimulus,
// a per-cycle vector table plus a hand-written mid-word reset sequence.
module tb_vector_stream_splitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       rdy_msb, rdy_lsb, ov_msb, ov_lsb, last_msb, last_lsb;
  logic [1:0] data_msb, data_lsb, idx_msb, idx_lsb;
`ifdef VSPLIT_PARITY_EN
  logic       par_msb, par_lsb;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_stream_splitter #(.IN_W(8), .SLICE_W(2), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_msb), .in_data(in_data),
    .out_valid(ov_msb), .out_ready(out_ready), .out_data(data_msb), .out_idx(idx_msb),
    .out_last(last_msb)
`ifdef VSPLIT_PARITY_EN
    , .out_par(par_msb)
`endif
  );

  vector_stream_splitter #(.IN_W(8), .SLICE_W(2), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_lsb), .in_data(in_data),
    .out_valid(ov_lsb), .out_ready(out_ready), .out_data(data_lsb), .out_idx(idx_lsb),
    .out_last(last_lsb)
`ifdef VSPLIT_PARITY_EN
    , .out_par(par_lsb)
`endif
  );

  typedef struct {
    logic       rst, iv;
    logic [7:0] din;
    logic       ordy;
    logic       chk, dchk;
    logic       e_inr, e_ov;
    logic [1:0] e_msb, e_lsb, e_idx;
    logic       e_last;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic ordy, logic chk, logic dchk,
                              logic inr, logic ov, logic [1:0] m, logic [1:0] l, logic [1:0] idx,
                              logic last);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy; v.chk = chk; v.dchk = dchk;
    v.e_inr = inr; v.e_ov = ov; v.e_msb = m; v.e_lsb = l; v.e_idx = idx; v.e_last = last;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(logic dchk, logic inr, logic ov, logic [1:0] m, logic [1:0] l,
                           logic [1:0] idx, logic last);
    check("msb.in_ready", {7'b0, rdy_msb}, {7'b0, inr});
    check("lsb.in_ready", {7'b0, rdy_lsb}, {7'b0, inr});
    check("msb.out_valid", {7'b0, ov_msb}, {7'b0, ov});
    check("lsb.out_valid", {7'b0, ov_lsb}, {7'b0, ov});
    check("msb.out_idx", {6'b0, idx_msb}, {6'b0, idx});
    check("lsb.out_idx", {6'b0, idx_lsb}, {6'b0, idx});
    check("msb.out_last", {7'b0, last_msb}, {7'b0, last});
    check("lsb.out_last", {7'b0, last_lsb}, {7'b0, last});
    if (dchk) begin
      check("msb.out_data", {6'b0, data_msb}, {6'b0, m});
      check("lsb.out_data", {6'b0, data_lsb}, {6'b0, l});
`ifdef VSPLIT_PARITY_EN
      check("msb.out_par", {7'b0, par_msb}, {7'b0, ^m});
      check("lsb.out_par", {7'b0, par_lsb}, {7'b0, ^l});
`endif
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset, single word D6, backpressure at idx1, back-to-back D6 -> 3C with junk AA ignored.
    vq.push_back(mk(1,0,8'h00,1, 0,0, 1,0,2'd0,2'd0,2'd0,0));
    vq.push_back(mk(1,0,8'h00,1, 1,1, 1,0,2'd0,2'd0,2'd0,0));
    vq.push_back(mk(0,1,8'hD6,1, 1,0, 1,0,2'd0,2'd0,2'd0,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 0,1,2'd3,2'd2,2'd0,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 0,1,2'd1,2'd1,2'd1,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 0,1,2'd1,2'd1,2'd2,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 1,1,2'd2,2'd3,2'd3,1));
    vq.push_back(mk(0,1,8'hD6,1, 1,0, 1,0,2'd0,2'd0,2'd0,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 0,1,2'd3,2'd2,2'd0,0));
    vq.push_back(mk(0,0,8'h00,0, 1,1, 0,1,2'd1,2'd1,2'd1,0));
    vq.push_back(mk(0,0,8'h00,0, 1,1, 0,1,2'd1,2'd1,2'd1,0));
    vq.push_back(mk(0,1,8'h55,0, 1,1, 0,1,2'd1,2'd1,2'd1,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 0,1,2'd1,2'd1,2'd1,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 0,1,2'd1,2'd1,2'd2,0));
    vq.push_back(mk(0,0,8'h00,0, 1,1, 0,1,2'd2,2'd3,2'd3,1));
    vq.push_back(mk(0,1,8'hD6,1, 1,1, 1,1,2'd2,2'd3,2'd3,1));
    vq.push_back(mk(0,1,8'hAA,1, 1,1, 0,1,2'd3,2'd2,2'd0,0));
    vq.push_back(mk(0,1,8'hAA,1, 1,1, 0,1,2'd1,2'd1,2'd1,0));
    vq.push_back(mk(0,1,8'hAA,1, 1,1, 0,1,2'd1,2'd1,2'd2,0));
    vq.push_back(mk(0,1,8'h3C,1, 1,1, 1,1,2'd2,2'd3,2'd3,1));
    vq.push_back(mk(0,1,8'hAA,1, 1,1, 0,1,2'd0,2'd0,2'd0,0));
    vq.push_back(mk(0,1,8'hAA,1, 1,1, 0,1,2'd3,2'd3,2'd1,0));
    vq.push_back(mk(0,1,8'hAA,1, 1,1, 0,1,2'd3,2'd3,2'd2,0));
    vq.push_back(mk(0,0,8'h00,1, 1,1, 1,1,2'd0,2'd0,2'd3,1));
    vq.push_back(mk(0,0,8'h00,1, 1,0, 1,0,2'd0,2'd0,2'd0,0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; in_valid = vq[i].iv; in_data = vq[i].din; out_ready = vq[i].ordy;
      #1;
      $display("vec %0d: rst=%0b iv=%0b din=%02h ordy=%0b -> ov=%0b inr=%0b idx=%0d last=%0b msb=%02b lsb=%02b",
               i, rst, in_valid, in_data, out_ready, ov_msb, rdy_msb, idx_msb, last_msb,
               data_msb, data_lsb);
      if (vq[i].chk)
        check_all(vq[i].dchk, vq[i].e_inr, vq[i].e_ov, vq[i].e_msb, vq[i].e_lsb,
                  vq[i].e_idx, vq[i].e_last);
    end

    // Mid-word reset at idx2, then FF must stream from idx0 with nothing of D6 left.
    @(negedge clk); in_valid = 1'b1; in_data = 8'hD6; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk); #1;
    check_all(1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    $display("rst seq: ov=%0b inr=%0b idx=%0d", ov_msb, rdy_msb, idx_msb);
    check_all(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'h00; #1;
      $display("ff seq %0d: ov=%0b idx=%0d msb=%02b lsb=%02b last=%0b",
               k, ov_msb, idx_msb, data_msb, data_lsb, last_msb);
      check_all(1'b1, k == 3, 1'b1, 2'b11, 2'b11, 2'(k), k == 3);
    end
    @(negedge clk); #1;
    check_all(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
